// File: rtl/kill_arbiter.sv
// Serialises simultaneous kill events from several sources into one-per-cycle score pulses.
// Per-source saturating backlog counters, round-robin grant, optional idle gap after each pulse.
module kill_arbiter #(
   parameter int unsigned N_SRC  = 4,
   parameter int unsigned PEND_W = 3,
   parameter int unsigned GAP    = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_SRC-1:0]           kill_req,
   input  logic                       enable,
   input  logic                       clear,
   output logic                       killed,
   output logic [$clog2(N_SRC)-1:0]   grant_idx,
   output logic                       pending_any,
   output logic                       dropped
);

   localparam int unsigned IDX_W = $clog2(N_SRC);
   localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [PEND_W-1:0] PMAX = '1;

   typedef enum logic [0:0] {StReady, StHold} state_e;

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [PEND_W-1:0]   pend_q [N_SRC];
   logic [PEND_W-1:0]   pend_d [N_SRC];
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic                killed_q, killed_d;
   logic                dropped_q, dropped_d;

   logic                eligible;
   logic                win_valid;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    cand;
   logic                inc;
   logic                dec;

   assign eligible = (state_q == StReady) && enable && !clear;

   // Cyclic search starting just after the last granted source.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         cand = IDX_W'((32'(last_q) + k) % N_SRC);
         if (!win_valid && (pend_q[cand] != '0)) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
      if (!eligible) begin
         win_valid = 1'b0;
      end
   end

   always_comb begin
      pend_d      = pend_q;
      state_d     = state_q;
      gap_d       = gap_q;
      last_d      = last_q;
      grant_idx_d = grant_idx_q;
      killed_d    = 1'b0;
      dropped_d   = 1'b0;
      inc         = 1'b0;
      dec         = 1'b0;
      if (clear) begin
         for (int i = 0; i < N_SRC; i++) begin
            pend_d[i] = '0;
         end
         state_d = StReady;
         gap_d   = '0;
      end else begin
         // The hold countdown runs even while paused.
         if (state_q == StHold) begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) begin
               state_d = StReady;
            end
         end
         if (win_valid) begin
            killed_d    = 1'b1;
            grant_idx_d = win_idx;
            last_d      = win_idx;
            if (GAP > 0) begin
               state_d = StHold;
               gap_d   = GAP_W'(GAP);
            end
         end
         for (int i = 0; i < N_SRC; i++) begin
            inc = enable && kill_req[i];
            dec = win_valid && (win_idx == IDX_W'(i));
            if (inc && !dec) begin
               if (pend_q[i] == PMAX) begin
                  dropped_d = 1'b1;
               end else begin
                  pend_d[i] = pend_q[i] + PEND_W'(1);
               end
            end else if (dec && !inc) begin
               pend_d[i] = pend_q[i] - PEND_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_SRC; i++) begin
            pend_q[i] <= '0;
         end
         state_q     <= StReady;
         gap_q       <= '0;
         last_q      <= IDX_W'(N_SRC - 1);
         grant_idx_q <= '0;
         killed_q    <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         state_q     <= state_d;
         gap_q       <= gap_d;
         last_q      <= last_d;
         grant_idx_q <= grant_idx_d;
         killed_q    <= killed_d;
         dropped_q   <= dropped_d;
      end
   end

   always_comb begin
      pending_any = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pend_q[i] != '0) begin
            pending_any = 1'b1;
         end
      end
   end

   assign killed    = killed_q;
   assign grant_idx = grant_idx_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_kill_arbiter.sv
// Bench for kill_arbiter: a GAP=0 and a GAP=2 instance share stimulus and are each
// compared every cycle against a backlog/round-robin reference, plus directed sequences.
module tb_kill_arbiter;

   localparam int N    = 4;
   localparam int PW   = 3;
   localparam int PMAX = (1 << PW) - 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] kill_req;
   logic       enable;
   logic       clear;
   logic       k0, k2, d0, d2, pa0, pa2;
   logic [1:0] g0, g2;

   always #5 clk = ~clk;

   kill_arbiter #(.N_SRC(4), .PEND_W(3), .GAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .kill_req(kill_req), .enable(enable), .clear(clear),
      .killed(k0), .grant_idx(g0), .pending_any(pa0), .dropped(d0)
   );

   kill_arbiter #(.N_SRC(4), .PEND_W(3), .GAP(2)) u_dut2 (
      .clk(clk), .reset(reset), .kill_req(kill_req), .enable(enable), .clear(clear),
      .killed(k2), .grant_idx(g2), .pending_any(pa2), .dropped(d2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: index 0 models the GAP=0 instance, index 1 the GAP=2 instance.
   int m_gap [2] = '{0, 2};
   int m_pend [2][N];
   int m_last [2];
   int m_hold [2];
   int m_gidx [2];
   int m_counted [2];
   bit m_killed [2];
   bit m_dropped [2];

   typedef struct {
      logic [3:0] req;
      logic       en;
      logic       clr;
      logic       exp_k;
      int         exp_g;
      logic       exp_pa;
      logic       exp_d;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic model_reset(input int m);
      for (int i = 0; i < N; i++) m_pend[m][i] = 0;
      m_last[m]    = N - 1;
      m_hold[m]    = 0;
      m_gidx[m]    = 0;
      m_killed[m]  = 0;
      m_dropped[m] = 0;
      m_counted[m] = 0;
   endtask

   task automatic model_edge(input int m);
      int w;
      int idx;
      w = -1;
      if (clear) begin
         for (int i = 0; i < N; i++) m_pend[m][i] = 0;
         m_killed[m]  = 0;
         m_dropped[m] = 0;
         m_hold[m]    = 0;
      end else begin
         if (m_hold[m] == 0 && enable) begin
            for (int k = 1; k <= N; k++) begin
               idx = (m_last[m] + k) % N;
               if (w < 0 && m_pend[m][idx] > 0) w = idx;
            end
         end
         if (m_hold[m] > 0) m_hold[m]--;
         m_killed[m]  = (w >= 0);
         m_dropped[m] = 0;
         if (w >= 0) begin
            m_gidx[m] = w;
            m_last[m] = w;
            m_pend[m][w]--;
            m_hold[m] = m_gap[m];
         end
         if (enable) begin
            for (int i = 0; i < N; i++) begin
               if (kill_req[i]) begin
                  if (m_pend[m][i] == PMAX) m_dropped[m] = 1;
                  else begin
                     m_pend[m][i]++;
                     m_counted[m]++;
                  end
               end
            end
         end
      end
   endtask

   function automatic int model_pany(input int m);
      int any;
      any = 0;
      for (int i = 0; i < N; i++) if (m_pend[m][i] > 0) any = 1;
      return any;
   endfunction

   task automatic compare_models();
      check("g0 killed", int'(k0), int'(m_killed[0]));
      check("g0 grant_idx", int'(g0), m_gidx[0]);
      check("g0 pending_any", int'(pa0), model_pany(0));
      check("g0 dropped", int'(d0), int'(m_dropped[0]));
      check("g2 killed", int'(k2), int'(m_killed[1]));
      check("g2 grant_idx", int'(g2), m_gidx[1]);
      check("g2 pending_any", int'(pa2), model_pany(1));
      check("g2 dropped", int'(d2), int'(m_dropped[1]));
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (!reset) model_reset(m);
         else model_edge(m);
      end
      #1;
      compare_models();
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      kill_req = 4'b0000;
      enable   = 1'b1;
      clear    = 1'b0;
      for (int m = 0; m < 2; m++) model_reset(m);
      cycle();
      cycle();
      reset = 1'b1;
   endtask

   initial begin
      int n_kill;
      int n_drop;
      int prev;

      vecs[0] = '{4'b1111, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0};
      vecs[1] = '{4'b0000, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0};
      vecs[2] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
      vecs[3] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0};
      vecs[4] = '{4'b0000, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0};
      vecs[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
      vecs[6] = '{4'b0100, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0};
      vecs[7] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      vecs[8] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};

      // Reset values
      do_reset();
      check("reset killed", int'(k0), 0);
      check("reset grant_idx", int'(g0), 0);
      check("reset pending_any", int'(pa0), 0);
      check("reset dropped", int'(d2), 0);

      // Table: burst on all sources, then a lone request on source 2 (GAP=0 instance)
      for (int v = 0; v < 9; v++) begin
         kill_req = vecs[v].req;
         enable   = vecs[v].en;
         clear    = vecs[v].clr;
         cycle();
         check($sformatf("vec%0d killed", v), int'(k0), int'(vecs[v].exp_k));
         check($sformatf("vec%0d grant_idx", v), int'(g0), vecs[v].exp_g);
         check($sformatf("vec%0d pending_any", v), int'(pa0), int'(vecs[v].exp_pa));
         check($sformatf("vec%0d dropped", v), int'(d0), int'(vecs[v].exp_d));
      end

      // Saturation on source 1 with GAP=2
      do_reset();
      n_kill = 0;
      n_drop = 0;
      prev   = -1;
      for (int c = 0; c < 60; c++) begin
         kill_req = (c < 20) ? 4'b0010 : 4'b0000;
         cycle();
         if (d2) n_drop++;
         if (k2) begin
            if (prev >= 0) check("gap2 pulse spacing", c - prev, 3);
            prev = c;
            n_kill++;
         end
      end
      check("gap2 drained", int'(pa2), 0);
      check("gap2 kills equal counted", n_kill, m_counted[1]);
      check("gap2 drops equal lost", n_drop, 20 - m_counted[1]);
      check("gap2 saturation seen", int'(n_drop > 0), 1);

      // Fairness: sources 0 and 3 request every cycle
      do_reset();
      kill_req = 4'b1001;
      n_kill   = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (k0) begin
            check("fair grant order", int'(g0), (n_kill % 2 == 0) ? 0 : 3);
            n_kill++;
         end
      end
      check("fair pulse count", n_kill, 11);

      // Clear mid-drain with a simultaneous request
      do_reset();
      kill_req = 4'b0010;
      for (int c = 0; c < 5; c++) cycle();
      clear = 1'b1;
      cycle();
      check("clear killed g0", int'(k0), 0);
      check("clear killed g2", int'(k2), 0);
      check("clear pending g0", int'(pa0), 0);
      check("clear pending g2", int'(pa2), 0);
      clear    = 1'b0;
      kill_req = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         cycle();
         check("post-clear idle g0", int'(k0), 0);
         check("post-clear idle g2", int'(k2), 0);
      end

      // Pause holds the backlog; asynchronous reset mid-drain
      do_reset();
      kill_req = 4'b1111;
      cycle();
      enable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         kill_req = 4'($urandom);
         cycle();
         check("paused killed g0", int'(k0), 0);
         check("paused killed g2", int'(k2), 0);
         check("paused backlog g0", int'(pa0), 1);
      end
      enable   = 1'b1;
      kill_req = 4'b0000;
      cycle();
      cycle();
      check("resume drain g0", int'(k0), 1);
      #3;
      reset = 1'b0;
      for (int m = 0; m < 2; m++) model_reset(m);
      #1;
      check("async reset killed g0", int'(k0), 0);
      check("async reset grant_idx g0", int'(g0), 0);
      check("async reset pending g0", int'(pa0), 0);
      check("async reset pending g2", int'(pa2), 0);
      compare_models();
      cycle();
      reset = 1'b1;
      cycle();

      // Randomized traffic against the reference
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         kill_req = (c % 200 < 100) ? 4'($urandom) : (4'($urandom) & 4'($urandom));
         enable   = ($urandom_range(9) != 0);
         clear    = ($urandom_range(39) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kill_arbiter.md
Name: kill_arbiter

Overview:
- Collects kill events from N_SRC independent sources (enemy/bullet collision units) that may fire in the same cycle.
- Serialises them into the single-pulse killed input of the scoreboard, which accepts at most one increment per cycle.
- Buffers per-source pending kills in saturating counters and grants round-robin, with an optional minimum gap between increments.
- Sits between the collision logic and the score block.

Parameters:
- N_SRC, 4, number of kill sources (>= 2).
- PEND_W, 3, width of each per-source pending counter; saturates at PMAX = 2^PEND_W - 1.
- GAP, 0, number of idle cycles forced after each killed pulse (0 = back-to-back pulses allowed).

Ports:
- clk  in  1  50MHz system clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0).
- kill_req  in  N_SRC  bit i high for one cycle = one kill from source i; multiple bits may be high together.
- enable  in  1  1 = game running; 0 = paused.
- clear  in  1  synchronous flush of all pending kills (e.g. at new game).
- killed  out  1  one-cycle pulse = one score increment; drives the scoreboard killed input.
- grant_idx  out  $clog2(N_SRC)  source credited by the current killed pulse; holds its last value when killed=0.
- pending_any  out  1  1 if any pending counter is nonzero (registered state, not combinational from kill_req).
- dropped  out  1  one-cycle pulse when a request is lost to saturation.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pending counters = 0.
  - killed = 0, grant_idx = 0, dropped = 0.
  - Round-robin pointer last = N_SRC-1, so source 0 has priority first.
  - FSM = READY, gap counter = 0.
  - Outputs stay at these values until the first rising clk edge after reset returns to 1.
- Registers: pend[i], PEND_W bits per source; last; FSM state in {READY, HOLD}; gap counter of width $clog2(GAP+1), minimum 1.
- Arbitration (combinational, on registered state):
  - Eligible when FSM=READY and enable=1 and clear=0.
  - Winner = first i with pend[i] != 0, searching cyclically from last+1 through last (modulo N_SRC).
- At each rising edge:
  - clear=1 has priority over everything:
    - all pend = 0, killed = 0, dropped = 0, FSM = READY, gap = 0.
    - last and grant_idx keep their values.
    - kill_req that same cycle is discarded.
  - Else, if a winner w exists:
    - killed <= 1, grant_idx <= w, last <= w.
    - pend[w] decrements.
    - If GAP>0: FSM <= HOLD, gap <= GAP.
  - Else killed <= 0.
  - Request counting, only when enable=1 and clear=0: pend[i] increments when kill_req[i]=1.
  - Simultaneous increment and decrement on one source: pend[i] unchanged.
  - Saturation: pend[i]=PMAX with kill_req[i]=1 and no grant to i → pend stays PMAX and dropped <= 1.
    - dropped is a single pulse even if several sources drop in the same cycle.
    - Otherwise dropped <= 0.
  - enable=0: kill_req ignored (not counted, no dropped), no grants, pend and FSM-hold countdown preserved (gap keeps decrementing).
- FSM:
  - READY: may grant.
  - HOLD: no grant. gap decrements each edge; gap=1 → next state READY.
  - GAP=0: HOLD is never entered.
- Latency:
  - kill_req sampled at edge k → pend updated at k.
  - If no contention, killed=1 after edge k+1, lasting exactly one cycle.
- Throughput: one killed pulse per (GAP+1) cycles maximum.
- Kills are never lost except by saturation or clear. Every counted request eventually produces exactly one killed pulse while enable=1.
- pending_any = |pend, from registers.

Test Plan:
- Reset, then single kill_req[2] pulse at edge 1 → killed=1 for exactly the cycle after edge 2, grant_idx=2; pending_any=1 for the cycle after edge 1, then 0.
- All 4 bits high for one cycle, GAP=0 → killed high 4 consecutive cycles with grant_idx 0,1,2,3; then killed=0 and pending_any=0.
- kill_req[1] held high 20 cycles with enable=1, GAP=2 → pend[1] saturates at 7. dropped pulses whenever an increment is lost. Total killed pulses = counted requests, each separated by exactly 2 idle cycles.
- Sources 0 and 3 each request every cycle, GAP=0 → grant_idx alternates 0,3,0,3 (fairness, no starvation).
- Queue 5 kills on source 1, assert clear for one cycle mid-drain with a simultaneous kill_req[1] → killed=0 next cycle; pend[1]=0; no further pulses.
- Pending kills with enable=0 for 10 cycles → no killed, kill_req ignored. Re-enable → backlog drains. Assert reset=0 mid-drain → killed drops to 0 immediately (asynchronously); all state cleared.
